// File: rtl/muldiv_if.sv
// Handshake and result bundle between the decode stage and the HI/LO multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [5:0]  Function_opcode;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, Function_opcode, read_data_1, read_data_2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, Function_opcode, read_data_1, read_data_2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply / restoring divide unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN to finish mult/multu in a single step (div latency unchanged).
module muldiv_unit (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMtlo  = 6'b010011;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_hi_q, acc_hi_d;   // mult: upper product; div: partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;   // mult: multiplier/lower product; div: dividend/quotient
  logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;         // result (product/quotient) must be negated
  logic        rem_neg_q, rem_neg_d; // remainder takes the dividend's sign
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, shifted, diff;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod;
  logic        last;

  assign signed_op = (bus.Function_opcode == FnMult) || (bus.Function_opcode == FnDiv);
  assign a_neg     = signed_op & bus.read_data_1[31];
  assign b_neg     = signed_op & bus.read_data_2[31];
  assign a_mag     = a_neg ? (~bus.read_data_1 + 32'd1) : bus.read_data_1;
  assign b_mag     = b_neg ? (~bus.read_data_2 + 32'd1) : bus.read_data_2;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    step_hi   = acc_hi_q;
    step_lo   = acc_lo_q;
    prod      = '0;
    last      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.Function_opcode)
            FnMult, FnMultu, FnDiv, FnDivu: begin
              is_div_d  = (bus.Function_opcode == FnDiv) || (bus.Function_opcode == FnDivu);
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dz_d      = (bus.read_data_2 == 32'd0);
              count_d   = 5'd0;
              acc_hi_d  = 32'd0;
              acc_lo_d  = is_div_d ? a_mag : b_mag;
              opnd_d    = is_div_d ? b_mag : a_mag;
              state_d   = StBusy;
            end
            FnMthi:  hi_d = bus.read_data_1;
            FnMtlo:  lo_d = bus.read_data_1;
            default: ;
          endcase
        end
      end
      StBusy: begin
        count_d = count_q + 5'd1;
        last    = (count_q == 5'd31);
        if (is_div_q) begin
          shifted = {acc_hi_q, acc_lo_q[31]};
          diff    = shifted - {1'b0, opnd_q};
          if (shifted >= {1'b0, opnd_q}) begin
            step_hi = diff[31:0];
            step_lo = {acc_lo_q[30:0], 1'b1};
          end else begin
            step_hi = shifted[31:0];
            step_lo = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {step_hi, step_lo} = {32'd0, opnd_q} * {32'd0, acc_lo_q};
          last = 1'b1;
`else
          sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
          {step_hi, step_lo} = {sum, acc_lo_q[31:1]};
`endif
        end
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;

        if (last) begin
          if (is_div_q) begin
            lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~step_lo + 32'd1) : step_lo);
            hi_d = rem_neg_q ? (~step_hi + 32'd1) : step_hi;
          end else begin
            prod = neg_q ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; all widths are fixed at 32 bits.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request; sampled with Function_opcode and operands.
REQ-005 Function_opcode  input  6  R-type funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
REQ-006 read_data_1  input  32  rs operand from decoder (multiplicand/dividend; mthi/mtlo source).
REQ-007 read_data_2  input  32  rt operand from decoder (multiplier/divisor).
REQ-008 busy  output  1  high while an iterative operation is in progress; the core stalls on it.
REQ-009 done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
REQ-010 hi  output  32  HI register, registered, feeds mfhi.
REQ-011 lo  output  32  LO register, registered, feeds mflo.

Function
REQ-012 FSM states: IDLE, BUSY; the iteration counter is 5 bits, 0..31.
REQ-013 IDLE with start and funct in {mult, multu, div, divu}: operands are captured at that edge N, count is cleared to 0, and the FSM enters BUSY.
REQ-014 BUSY: one shift-add (mult) or one restoring-subtract (div) step per edge; count increments.
REQ-015 The edge at which count==31 is stepped writes hi/lo, sets done for exactly the following cycle, and returns the FSM to IDLE; results are visible after edge N+32.
REQ-016 busy is high from the cycle after edge N through edge N+32 inclusive, and is driven combinationally from state==BUSY.
REQ-017 Unknown funct with start: ignored, no state change.
REQ-018 IDLE with start and mthi or mtlo: read_data_1 is written to hi or lo at the same edge; busy and done stay low.
REQ-019 start while BUSY, for any funct including mthi/mtlo: ignored; the operation in flight is unaffected.
REQ-020 mult/div in flight: hi/lo hold their previous values until the completing edge.
REQ-021 mult: signed 32x32 gives a 64-bit result; hi=[63:32], lo=[31:0]. multu is the unsigned equivalent.
REQ-022 divu: lo=quotient, hi=remainder.
REQ-023 div: operate on magnitudes; quotient is negated if operand signs differ; remainder takes the dividend's sign.
REQ-024 Divide by zero (div or divu): hi=read_data_1 as captured, lo=32'hFFFF_FFFF; latency is still 32 steps.
REQ-025 div 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0x0000_0000.
REQ-026 The next start is accepted in the cycle done is high (the FSM is already IDLE).

Reset
REQ-027 reset at posedge: state=IDLE, count=0, hi=0, lo=0, done=0, busy=0.
REQ-028 reset mid-BUSY aborts the operation; no partial result reaches hi/lo.
REQ-029 reset takes priority over start in the same cycle.

Configuration
REQ-030 With macro MULDIV_FAST_MUL_EN defined, mult/multu complete in one step: hi/lo are written at edge N+1, done pulses in the following cycle, and busy is high for one cycle only.
REQ-031 Without MULDIV_FAST_MUL_EN, mult/multu use the 32-step iterative path of REQ-014/015.
REQ-032 div/divu latency is identical in both builds.

Verification
REQ-033 multu 0xFFFF_FFFF x 0xFFFF_FFFF -> after 32 steps, hi=0xFFFF_FFFE and lo=0x0000_0001; done is high for 1 cycle (1 step when MULDIV_FAST_MUL_EN is defined).
REQ-034 mult -3 x 7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; a start issued mid-BUSY with mthi 0x1234 leaves hi unaffected.
REQ-035 div -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; div 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
REQ-036 divu 100 / 0 -> hi=0x0000_0064, lo=0xFFFF_FFFF, with busy high for 32 cycles.
REQ-037 mtlo 0xDEAD_BEEF in IDLE -> lo=0xDEAD_BEEF next cycle with busy=0; then mult with reset at step 10 -> hi=lo=0, busy=0, done never pulses.
